fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO. Successor to the fixed 16-bit FIFO.
- Adds the following over the fixed block:
  - true full at 2**ADDR_WIDTH entries;
  - fill-level output;
  - programmable almost-full and almost-empty flags;
  - sticky overflow and underflow flags;
  - synchronous flush;
  - optional first-word-fall-through read mode.
- Sits between RFSoC datapath producers and consumers, for example sample streams and command queues.

Parameters:
- DATA_WIDTH, 16, width of din/dout.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AF_THRESH, 2**ADDR_WIDTH-2, almost_full asserted when level >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and flags.
- din  in  DATA_WIDTH  write data.
- write  in  1  write request.
- read  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_empty  out  1  level <= AE_THRESH.
- almost_full  out  1  level >= AF_THRESH.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (async, active-high):
  - head, tail and level go to 0; overflow, underflow and dout go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (given AF_THRESH>0).
  - Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first accepted write after reset deassertion lands at address 0.
- Internal pointers:
  - head and tail are ADDR_WIDTH bits and wrap modulo DEPTH naturally.
  - level is a separate ADDR_WIDTH+1-bit counter, so the FIFO holds DEPTH entries, not DEPTH-1.
- Acceptance rules:
  - wr_acc = write & ~full.
  - rd_acc = read & ~empty.
  - Both are evaluated on the pre-edge flags.
- Level and pointer update:
  - wr_acc only: mem[head] <= din, head+1, level+1.
  - rd_acc only: tail+1, level-1.
  - wr_acc and rd_acc together: both pointers advance, level unchanged.
- Simultaneous read+write when empty: only the write is accepted, level becomes 1, and underflow is set.
- Simultaneous read+write when full: only the read is accepted, level becomes DEPTH-1, and overflow is set. The write data is dropped.
- Flag timing:
  - empty, full, almost_* are decoded combinationally from the registered level.
  - They change in the same cycle level changes, i.e. one edge after the access.
- Sticky flags:
  - overflow is set on the edge after write & full; underflow is set on the edge after read & empty.
  - Both hold until reset or flush.
- flush:
  - Takes priority over read and write in the same cycle.
  - Next edge: head=tail=level=0, overflow=underflow=0, dout=0.
  - read and write in the flush cycle are ignored.
- Standard read mode (macro undefined):
  - dout <= mem[tail] on the edge where rd_acc=1, so read latency is 1 cycle.
  - dout holds its value otherwise.
- Threshold parameters:
  - AF_THRESH must be in 1..DEPTH; AE_THRESH must be in 0..DEPTH-1.
  - Out-of-range values are an elaboration error.

Optional Feature:
- Macro: FIFO_SYNC_PARAM_FWFT_EN.
- Defined: first-word-fall-through mode.
  - dout = mem[tail] combinationally whenever empty=0; dout = 0 while empty=1.
  - A word written at edge N is visible on dout, with empty=0, after edge N.
  - Asserting read with empty=0 consumes the presented word; the next word, or 0, appears after that edge.
  - The dout register is not implemented.
- Undefined: standard registered read with 1-cycle latency, as specified in Behaviour.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=3, DEPTH=8, AF_THRESH=6, AE_THRESH=2):
1. Reset, then write 0x0001..0x0008 on consecutive cycles -> level 1..8; almost_empty drops at level 3; almost_full rises at level 6; full=1 at level 8; overflow=0.
2. From full, 1 cycle of write=1 din=0xDEAD -> level stays 8, overflow=1. Then 8 reads -> dout 0x0001..0x0008 in order (1-cycle latency standard, 0-cycle FWFT), empty=1.
3. Empty FIFO, read=1 write=1 din=0x00AA -> level=1, underflow=1. Next cycle read -> dout=0x00AA, level=0.
4. Wrap-around: fill 5 entries, then 20 cycles of simultaneous read+write with incrementing data -> level constant 5, output order strictly incrementing, no flags set.
5. level=4 with overflow=1; assert flush with write=1 -> next edge level=0, empty=1, overflow=0, dout=0, and the written word is not stored.
6. Assert reset asynchronously mid-cycle while level=3 -> outputs go to reset values before the next clk edge. After release, write 0x1234 and read -> dout=0x1234.

Source files
------------

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO for datapath producer/consumer decoupling
//   (sample streams, command queues). Holds a full 2**ADDR_WIDTH entries by
//   tracking occupancy in a separate counter rather than deriving it from the
//   pointers.
//
// Build option:
//   FIFO_SYNC_PARAM_FWFT_EN  defined   -> first-word-fall-through read mode:
//                                         dout shows the head word combinationally
//                                         (0 while empty), no output register.
//                            undefined -> registered read, dout updates on the
//                                         edge that accepts a read.
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous active-high reset
//   flush         in   synchronous clear of contents and sticky flags
//   din           in   [DATA_WIDTH-1:0] write data
//   write         in   write request (ignored while full)
//   read          in   read request (ignored while empty)
//   dout          out  [DATA_WIDTH-1:0] read data
//   empty         out  level == 0
//   full          out  level == DEPTH
//   almost_empty  out  level <= AE_THRESH
//   almost_full   out  level >= AF_THRESH
//   level         out  [ADDR_WIDTH:0] occupancy, 0..DEPTH
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   LVL_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   LVL_AE    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    generate
        if (AF_THRESH < 1 || AF_THRESH > DEPTH ||
            AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
            $error("fifo_sync_param: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags decode from the registered level, so they move one edge after
    // the access that changed it.
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_DEPTH);
    assign w_wr_acc = write & ~w_full;
    assign w_rd_acc = read  & ~w_empty;

    // Storage is deliberately not reset; only pointers and level define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_wr_acc) begin
            r_mem[r_head] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_tail <= r_tail + PTR_ONE;
            end
            // Simultaneous accepted read and write leaves level unchanged.
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (write && w_full) begin
                r_overflow <= 1'b1;
            end
            if (read && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    // Head word falls through; forced to 0 so stale storage never leaks out.
    assign dout = w_empty ? '0 : r_mem[r_tail];
`else
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
        end else if (flush) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= r_mem[r_tail];
        end
    end

    assign dout = r_dout;
`endif

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_level <= LVL_AE);
    assign almost_full  = (r_level >= LVL_AF);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
